// File: rtl/da_pkg.sv
// Shared constants, types and helpers for the DA filter result reader.
package da_pkg;

   localparam int DA_WORD_WIDTH = 16;

   typedef logic [DA_WORD_WIDTH-1:0] word_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/da_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers and an occupancy counter.
// A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module da_sync_fifo
   import da_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rdata,
   output logic                      full,
   output logic                      empty,
   output logic [ptr_w(DEPTH)-1:0]   level
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // When full, the write slot is the head slot being popped this cycle.
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/da_result_reader.sv
// Captures one DA filter result per ts strobe into a FIFO and streams it out.
// Optional macro RESULT_TAG_EN adds a capture sequence tag on m_tag.
module da_result_reader
   import da_pkg::*;
#(
   parameter int WORD_WIDTH = DA_WORD_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ts,
   input  logic [WORD_WIDTH-1:0]         y,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WORD_WIDTH-1:0]         m_data,
`ifdef RESULT_TAG_EN
   output logic [TAG_WIDTH-1:0]          m_tag,
`endif
   output logic [ptr_w(FIFO_DEPTH)-1:0]  level,
   output logic                          ovf,
   input  logic                          clr_ovf
);

`ifdef RESULT_TAG_EN
   localparam int FW = WORD_WIDTH + TAG_WIDTH;
`else
   localparam int FW = WORD_WIDTH;
`endif

   logic          ts_q, ts_d;
   logic          ovf_q, ovf_d;
   logic          cap, pop, drop;
   logic          fifo_full, fifo_empty;
   logic [FW-1:0] fifo_wdata, fifo_rdata;

   assign cap     = ts & ~ts_q;
   assign m_valid = ~fifo_empty;
   assign pop     = m_valid & m_ready;
   assign drop    = cap & fifo_full & ~pop;
   assign ovf     = ovf_q;
   assign m_data  = fifo_rdata[WORD_WIDTH-1:0];

`ifdef RESULT_TAG_EN
   logic [TAG_WIDTH-1:0] tag_q, tag_d;

   // Dropped captures still advance the tag so gaps reveal the loss.
   assign fifo_wdata = {tag_q, y};
   assign m_tag      = fifo_rdata[FW-1:WORD_WIDTH];

   always_comb begin
      tag_d = tag_q;
      if (cap) begin
         tag_d = tag_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end
`else
   assign fifo_wdata = y;
`endif

   always_comb begin
      ts_d  = ts;
      ovf_d = ovf_q;
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         ts_q  <= ts_d;
         ovf_q <= ovf_d;
      end
   end

   da_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

endmodule

// File: tb/tb_da_result_reader.sv
// Scoreboard bench for da_result_reader; define RESULT_TAG_EN to also check tags.
module tb_da_result_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ts;
   logic [15:0] y;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [3:0]  level;
   logic        ovf;
   logic        clr_ovf;
`ifdef RESULT_TAG_EN
   logic [7:0]  m_tag;
`endif

   typedef struct {
      logic [15:0] data;
      logic [7:0]  tag;
      bit          chk_tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   da_result_reader #(
      .WORD_WIDTH (16),
      .FIFO_DEPTH (8),
      .TAG_WIDTH  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ts      (ts),
      .y       (y),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
`ifdef RESULT_TAG_EN
      .m_tag   (m_tag),
`endif
      .level   (level),
      .ovf     (ovf),
      .clr_ovf (clr_ovf)
   );

   // Monitor: every accepted output must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %h, required nothing", m_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (m_data !== e.data) begin
               errors++;
               $display("FAIL stream_data got %h, required %h", m_data, e.data);
            end
`ifdef RESULT_TAG_EN
            if (e.chk_tag) begin
               checks++;
               if (m_tag !== e.tag) begin
                  errors++;
                  $display("FAIL stream_tag got %0d, required %0d", m_tag, e.tag);
               end
            end
`endif
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_data(input logic [15:0] d);
      exp_t e;
      e.data = d; e.tag = '0; e.chk_tag = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic expect_tagged(input logic [15:0] d, input logic [7:0] t);
      exp_t e;
      e.data = d; e.tag = t; e.chk_tag = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic pulse(input logic [15:0] v);
      ts = 1'b1; y = v;
      tick();
      ts = 1'b0; y = '0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      m_ready = 1'b1;
      while (m_valid && n < 20) begin
         tick();
         n++;
      end
      m_ready = 1'b0;
      chk("drain_done", {31'd0, m_valid}, 32'd0);
      chk("drain_sb_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got running, required finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ts = 1'b0; y = '0; m_ready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_valid", {31'd0, m_valid}, 32'd0);
      chk("reset_level", {28'd0, level}, 32'd0);
      chk("reset_ovf", {31'd0, ovf}, 32'd0);
      chk("reset_data", {16'd0, m_data}, 32'd0);

      // Basic capture with one-cycle latency and hold under backpressure
      ts = 1'b1; y = 16'h1234;
      tick();
      ts = 1'b0; y = '0;
      expect_data(16'h1234);
      chk("basic_valid", {31'd0, m_valid}, 32'd1);
      chk("basic_data", {16'd0, m_data}, 32'h1234);
      chk("basic_level", {28'd0, level}, 32'd1);
      tick(); tick();
      chk("basic_hold", {16'd0, m_data}, 32'h1234);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("basic_popped_valid", {31'd0, m_valid}, 32'd0);
      chk("basic_popped_level", {28'd0, level}, 32'd0);

      // Held strobe gives a single capture
      ts = 1'b1; y = 16'h00AA;
      repeat (4) tick();
      ts = 1'b0; y = '0;
      tick();
      expect_data(16'h00AA);
      chk("held_level", {28'd0, level}, 32'd1);
      drain();

      // Fill and overflow; drop coinciding with clr_ovf keeps ovf set
      for (int i = 1; i <= 9; i++) begin
         pulse(16'(i));
         if (i <= 8) expect_data(16'(i));
      end
      chk("ovf_level", {28'd0, level}, 32'd8);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      ts = 1'b1; y = 16'h0010; clr_ovf = 1'b1;
      tick();
      ts = 1'b0; y = '0; clr_ovf = 1'b0;
      tick();
      chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
      chk("ovf_head_kept", {16'd0, m_data}, 32'd1);
      drain();
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_cleared", {31'd0, ovf}, 32'd0);

      // Full FIFO with a capture and pop in the same cycle
      for (int i = 1; i <= 8; i++) begin
         pulse(16'(i));
         expect_data(16'(i));
      end
      chk("fullpop_pre_level", {28'd0, level}, 32'd8);
      ts = 1'b1; y = 16'h00FF; m_ready = 1'b1;
      expect_data(16'h00FF);
      tick();
      ts = 1'b0; y = '0; m_ready = 1'b0;
      chk("fullpop_level", {28'd0, level}, 32'd8);
      chk("fullpop_ovf", {31'd0, ovf}, 32'd0);
      chk("fullpop_head", {16'd0, m_data}, 32'd2);
      drain();

      // Reset mid-stream with ovf set and level 5
      for (int i = 1; i <= 9; i++) begin
         pulse(16'(i));
         if (i <= 8) expect_data(16'(i));
      end
      m_ready = 1'b1;
      repeat (3) tick();
      m_ready = 1'b0;
      chk("mid_level", {28'd0, level}, 32'd5);
      chk("mid_ovf", {31'd0, ovf}, 32'd1);
      do_reset();
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_level", {28'd0, level}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_data", {16'd0, m_data}, 32'd0);
      pulse(16'hBEEF);
      expect_data(16'hBEEF);
      chk("rst_beef_level", {28'd0, level}, 32'd1);
      chk("rst_beef_data", {16'd0, m_data}, 32'hBEEF);
      drain();

`ifdef RESULT_TAG_EN
      // Tags: 10 captures into 8 slots, tags 8 and 9 dropped
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         pulse(16'(i));
         if (i <= 8) expect_tagged(16'(i), 8'(i - 1));
      end
      chk("tag_head", {24'd0, m_tag}, 32'd0);
      chk("tag_ovf", {31'd0, ovf}, 32'd1);
      drain();
      pulse(16'h000B);
      expect_tagged(16'h000B, 8'd10);
      chk("tag_after_gap", {24'd0, m_tag}, 32'd10);
      drain();
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
